// File: rtl/des_stream_ctrl.sv
// Sequences a single-block DES core over multi-block ECB/CBC messages.
// Ports: cfg_* message setup, s_* input stream, m_* output stream,
//        core_* DES core pins, busy / err_timeout status.
module des_stream_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_mode,
    input  logic        cfg_cbc,
    input  logic [63:0] cfg_key,
    input  logic [63:0] cfg_iv,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [63:0] s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [63:0] m_data,
    output logic        m_last,
    output logic        core_start,
    output logic        core_mode,
    output logic [63:0] core_din,
    output logic [63:0] core_key,
    input  logic [63:0] core_dout,
    input  logic        core_valid,
    output logic        busy,
    output logic        err_timeout
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        OUT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic          msg_active;
    logic          last_r;
    logic          cbc_r;
    logic [63:0]   blk;
    logic [63:0]   chain;
    logic [CW-1:0] cnt;

    logic accept;
    logic timeout;

    // First block of a message takes cfg_*; later blocks use latched copies.
    logic        eff_mode;
    logic        eff_cbc;
    logic [63:0] eff_key;
    logic [63:0] eff_chain;

    assign eff_mode  = msg_active ? core_mode : cfg_mode;
    assign eff_cbc   = msg_active ? cbc_r     : cfg_cbc;
    assign eff_key   = msg_active ? core_key  : cfg_key;
    assign eff_chain = msg_active ? chain     : cfg_iv;

    assign busy = (state != IDLE) || msg_active;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        s_ready     = 1'b0;
        core_start  = 1'b0;
        m_valid     = 1'b0;
        err_timeout = 1'b0;
        accept      = 1'b0;
        timeout     = 1'b0;
        unique case (state)
            IDLE: begin
                s_ready = rst_n;
                if (s_valid && rst_n) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                core_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (core_valid) begin
                    state_nxt = OUT;
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    timeout     = 1'b1;
                    err_timeout = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            msg_active <= 1'b0;
            last_r     <= 1'b0;
            cbc_r      <= 1'b0;
            blk        <= '0;
            chain      <= '0;
            cnt        <= '0;
            m_data     <= '0;
            m_last     <= 1'b0;
            core_din   <= '0;
            core_mode  <= 1'b0;
            core_key   <= '0;
        end else begin
            if (accept) begin
                blk        <= s_data;
                last_r     <= s_last;
                cbc_r      <= eff_cbc;
                core_mode  <= eff_mode;
                core_key   <= eff_key;
                chain      <= eff_chain;
                msg_active <= 1'b1;
                if (eff_cbc && !eff_mode) begin
                    core_din <= s_data ^ eff_chain;
                end else begin
                    core_din <= s_data;
                end
            end
            if (state == START) begin
                cnt <= '0;
            end
            if (state == WAIT) begin
                if (core_valid) begin
                    m_last <= last_r;
                    if (cbc_r && core_mode) begin
                        m_data <= core_dout ^ chain;
                        chain  <= blk;
                    end else begin
                        m_data <= core_dout;
                        if (cbc_r) begin
                            chain <= core_dout;
                        end
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (timeout) begin
                msg_active <= 1'b0;
            end
            if (m_valid && m_ready && m_last) begin
                msg_active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_des_stream_ctrl.sv
// Scoreboard bench for des_stream_ctrl with a table-driven DES core model.
// Directed ECB/CBC vectors, backpressure, timeout and mid-WAIT reset.
module tb_des_stream_ctrl;

    localparam logic [63:0] KEY = 64'h133457799bbcdff1;
    localparam logic [63:0] PT  = 64'h0123456789abcdef;
    localparam logic [63:0] CT  = 64'h85e813540f0ab405;
    localparam logic [63:0] P2  = 64'h84cb563386a179ea;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_mode;
    logic        cfg_cbc;
    logic [63:0] cfg_key;
    logic [63:0] cfg_iv;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic        m_last;
    logic        core_start;
    logic        core_mode;
    logic [63:0] core_din;
    logic [63:0] core_key;
    logic [63:0] core_dout;
    logic        core_valid;
    logic        busy;
    logic        err_timeout;

    des_stream_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_mode(cfg_mode), .cfg_cbc(cfg_cbc),
        .cfg_key(cfg_key), .cfg_iv(cfg_iv),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last),
        .core_start(core_start), .core_mode(core_mode),
        .core_din(core_din), .core_key(core_key),
        .core_dout(core_dout), .core_valid(core_valid),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] din;
        logic        mode;
        logic [63:0] key;
    } din_exp_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } out_exp_t;

    din_exp_t din_q[$];
    out_exp_t out_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int starts   = 0;
    int hs       = 0;
    int errs     = 0;
    int mv_rises = 0;
    bit mv_prev  = 1'b0;

    int core_lat  = 1;
    bit core_mute = 1'b0;
    int pend      = 0;
    logic [63:0] res;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [63:0] des_ref(input logic [63:0] d,
                                            input logic m,
                                            input logic [63:0] k);
        if (k == KEY && !m && d == PT) return CT;
        if (k == KEY && m && d == CT) return PT;
        return ~d;
    endfunction

    always @(posedge clk) cyc++;

    // DES core model: result L cycles after the start pulse.
    initial begin
        core_valid = 1'b0;
        core_dout  = '0;
        forever begin
            @(posedge clk);
            #1;
            core_valid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0 && !core_mute) begin
                    core_valid = 1'b1;
                    core_dout  = res;
                end
            end
            if (core_start) begin
                pend = core_lat;
                res  = des_ref(core_din, core_mode, core_key);
            end
        end
    end

    // Monitor: pops scoreboard entries as the DUT presents them.
    initial begin
        din_exp_t de;
        out_exp_t oe;
        forever begin
            @(negedge clk);
            if (core_start) begin
                starts++;
                start_cyc = cyc;
                if (din_q.size() == 0) begin
                    bound_fail("unexpected_core_start");
                end else begin
                    de = din_q.pop_front();
                    chk("core_din", core_din, de.din);
                    chk("core_mode", {63'b0, core_mode}, {63'b0, de.mode});
                    chk("core_key", core_key, de.key);
                end
            end
            if (m_valid && !mv_prev) begin
                mv_rises++;
                chk("m_valid_latency", 64'(cyc - start_cyc),
                    64'(core_lat + 1));
            end
            mv_prev = m_valid;
            if (m_valid && m_ready) begin
                hs++;
                if (out_q.size() == 0) begin
                    bound_fail("unexpected_output");
                end else begin
                    oe = out_q.pop_front();
                    chk("m_data", m_data, oe.data);
                    chk("m_last", {63'b0, m_last}, {63'b0, oe.last});
                end
            end
            if (err_timeout) begin
                errs++;
                chk("timeout_delay", 64'(cyc - start_cyc), 64'd8);
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic l);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("send_accept");
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_q.size() == 0 && din_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("drain");
        repeat (2) @(negedge clk);
    endtask

    task automatic push_din(input logic [63:0] d, input logic m);
        din_exp_t e;
        e.din  = d;
        e.mode = m;
        e.key  = KEY;
        din_q.push_back(e);
    endtask

    task automatic push_out(input logic [63:0] d, input logic l);
        out_exp_t e;
        e.data = d;
        e.last = l;
        out_q.push_back(e);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_m_valid"}, {63'b0, m_valid}, 64'd0);
        chk({tag, "_m_data"}, m_data, 64'd0);
        chk({tag, "_m_last"}, {63'b0, m_last}, 64'd0);
        chk({tag, "_core_start"}, {63'b0, core_start}, 64'd0);
        chk({tag, "_core_din"}, core_din, 64'd0);
        chk({tag, "_core_mode"}, {63'b0, core_mode}, 64'd0);
        chk({tag, "_core_key"}, core_key, 64'd0);
        chk({tag, "_busy"}, {63'b0, busy}, 64'd0);
        chk({tag, "_err"}, {63'b0, err_timeout}, 64'd0);
    endtask

    initial begin
        int st0;
        int hs0;
        int e0;
        int mv0;
        bit ok;
        rst_n    = 1'b0;
        cfg_mode = 1'b0;
        cfg_cbc  = 1'b0;
        cfg_key  = KEY;
        cfg_iv   = 64'hdeadbeefcafef00d;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        m_ready  = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs("rst");
        chk("rst_s_ready", {63'b0, s_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", {63'b0, s_ready}, 64'd1);

        // ECB encrypt, single block
        push_din(PT, 1'b0);
        push_out(CT, 1'b1);
        send(PT, 1'b1);
        drain();
        chk("ecb_busy", {63'b0, busy}, 64'd0);

        // CBC encrypt, IV 0; cfg changes mid-message must not matter
        cfg_cbc = 1'b1;
        cfg_iv  = '0;
        push_din(PT, 1'b0);
        push_out(CT, 1'b0);
        push_din(PT, 1'b0);
        push_out(CT, 1'b1);
        send(PT, 1'b0);
        cfg_mode = 1'b1;
        cfg_key  = ~KEY;
        cfg_iv   = '1;
        send(P2, 1'b1);
        drain();
        chk("cbc_enc_busy", {63'b0, busy}, 64'd0);

        // CBC decrypt, IV 0
        cfg_mode = 1'b1;
        cfg_key  = KEY;
        cfg_iv   = '0;
        push_din(CT, 1'b1);
        push_out(PT, 1'b0);
        push_din(CT, 1'b1);
        push_out(P2, 1'b1);
        send(CT, 1'b0);
        send(CT, 1'b1);
        drain();

        // Backpressure: hold m_ready low 10 cycles in OUT
        cfg_mode = 1'b0;
        cfg_cbc  = 1'b0;
        m_ready  = 1'b0;
        push_din(PT, 1'b0);
        push_out(CT, 1'b1);
        send(PT, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("bp_m_valid");
        st0 = starts;
        hs0 = hs;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_m_valid", {63'b0, m_valid}, 64'd1);
            chk("bp_m_data", m_data, CT);
            chk("bp_m_last", {63'b0, m_last}, 64'd1);
            chk("bp_s_ready", {63'b0, s_ready}, 64'd0);
        end
        chk("bp_no_restart", 64'(starts), 64'(st0));
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        drain();
        chk("bp_one_handshake", 64'(hs), 64'(hs0 + 1));

        // Timeout: core never answers; next block reloads cfg_iv
        core_mute = 1'b1;
        cfg_cbc   = 1'b1;
        cfg_mode  = 1'b0;
        cfg_iv    = 64'h1111111111111111;
        e0  = errs;
        mv0 = mv_rises;
        push_din(PT ^ 64'h1111111111111111, 1'b0);
        send(PT, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (errs != e0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("timeout_pulse");
        repeat (5) @(negedge clk);
        chk("timeout_once", 64'(errs), 64'(e0 + 1));
        chk("timeout_no_mvalid", 64'(mv_rises), 64'(mv0));
        chk("timeout_busy", {63'b0, busy}, 64'd0);
        core_mute = 1'b0;
        cfg_iv    = '0;
        push_din(PT, 1'b0);
        push_out(CT, 1'b1);
        send(PT, 1'b1);
        drain();

        // Reset during WAIT; the late core_valid must be ignored
        core_lat = 5;
        cfg_cbc  = 1'b0;
        mv0 = mv_rises;
        push_din(PT, 1'b0);
        send(PT, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outs("midrst");
        chk("midrst_s_ready", {63'b0, s_ready}, 64'd1);
        repeat (10) @(negedge clk);
        chk("midrst_no_mvalid", 64'(mv_rises), 64'(mv0));
        chk("midrst_busy", {63'b0, busy}, 64'd0);

        // Recovery after reset
        core_lat = 1;
        push_din(PT, 1'b0);
        push_out(CT, 1'b1);
        send(PT, 1'b1);
        drain();

        chk("din_q_empty", 64'(din_q.size()), 64'd0);
        chk("out_q_empty", 64'(out_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/des_stream_ctrl.md
# des_stream_ctrl

Streaming controller that sequences the single-block DES core over multi-block messages in ECB or CBC chaining mode. It accepts 64-bit blocks on a valid/ready input stream and drives the core's start/mode/din/key pins. It captures the core result on its valid pulse, applies CBC chaining, and presents results on a valid/ready output stream. It sits between the bus-side FIFOs and the DES core and owns all per-message state: IV/chain register, latched key, mode and framing.

## Interface
- TIMEOUT_CYCLES, 64: maximum cycles to wait in WAIT for core_valid before aborting the message.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cfg_mode  in  1  0 = encrypt, 1 = decrypt; sampled on the first block of a message.
- cfg_cbc  in  1  1 = CBC, 0 = ECB; sampled on the first block.
- cfg_key  in  64  DES key (parity bits included); sampled on the first block.
- cfg_iv  in  64  CBC initial vector; loaded into the chain register on the first block.
- s_valid / s_ready / s_data[63:0] / s_last  in/out/in/in  input block stream; s_last marks the final block of a message.
- m_valid / m_ready / m_data[63:0] / m_last  out/in/out/out  output block stream.
- core_start  out  1  one-cycle start pulse to the DES core.
- core_mode  out  1  direction to the core.
- core_din  out  64  block to the core.
- core_key  out  64  key to the core.
- core_dout  in  64  core result.
- core_valid  in  1  one-cycle result pulse from the core.
- busy  out  1  high while a message is in progress or state != IDLE.
- err_timeout  out  1  one-cycle pulse when a core operation times out.

## Operation
- States: IDLE, START, WAIT, OUT.
- IDLE:
  - s_ready = 1 (0 while rst_n low).
  - On s_valid & s_ready: latch s_data into blk and s_last into last_r.
  - If msg_active = 0: latch cfg_mode, cfg_cbc and cfg_key; load chain <= cfg_iv; set msg_active.
  - Go to START.
- START:
  - core_start = 1 for exactly this cycle.
  - core_din is a register written on entry:
    - CBC encrypt: blk ^ chain.
    - Otherwise: blk.
  - core_din, core_mode and core_key are held stable from START until leaving WAIT.
  - Clear the timeout counter. Go to WAIT.
- WAIT:
  - On core_valid, register the result into m_data:
    - CBC decrypt: core_dout ^ chain.
    - Otherwise: core_dout.
  - On the same edge, update chain:
    - CBC encrypt: chain <= core_dout.
    - CBC decrypt: chain <= blk.
    - ECB: chain unchanged.
  - m_last <= last_r. Go to OUT.
  - Else increment the counter. When it reaches TIMEOUT_CYCLES: pulse err_timeout, clear msg_active, go to IDLE, emit nothing.
- OUT:
  - m_valid = 1; m_data and m_last are held until m_ready.
  - On m_valid & m_ready: if m_last, clear msg_active. Go to IDLE.
- core_valid outside WAIT is ignored.
- cfg_* changes during a message have no effect until the next message's first block.

## Timing
- Reset values (rst_n low at a clock edge): state IDLE, msg_active 0, chain 0, blk 0, m_valid 0, m_data 0, m_last 0, core_start 0, core_din 0, core_mode 0, core_key 0, busy 0, err_timeout 0, counter 0.
- Reset mid-operation aborts immediately. No output is produced for the in-flight block, and a later core_valid is ignored.
- Block accepted at edge T:
  - core_start is high in cycle T+1.
  - If core_valid arrives in cycle T+1+L, m_valid rises in cycle T+2+L.
- s_ready is low in START, WAIT and OUT; one block is in flight at a time.
- Back-to-back operation: after the OUT handshake, s_ready = 1 in the next cycle. Minimum block period = L + 3 cycles with m_ready held high.
- m_ready held low stalls indefinitely in OUT with m_data, m_valid and m_last stable.
- Timeout: err_timeout pulses TIMEOUT_CYCLES cycles after START. The next block (any s_last) starts a new message using current cfg_* values.
- Single-block message (s_last on the first block): msg_active sets and clears within the same message; the next block re-samples cfg_*.

## Test plan
- ECB encrypt, key 133457799bbcdff1:
  - Stimulus: block 0123456789abcdef with s_last.
  - Required: core_din = 0123456789abcdef; m_data = 85e813540f0ab405, m_last = 1; busy low afterward.
- CBC encrypt, IV 0, same key:
  - Stimulus: blocks 0123456789abcdef, then 84cb563386a179ea with s_last.
  - Required: core_din = 0123456789abcdef both times; outputs 85e813540f0ab405, 85e813540f0ab405 (m_last on the second).
- CBC decrypt, IV 0, same key:
  - Stimulus: blocks 85e813540f0ab405 twice.
  - Required: outputs 0123456789abcdef, then 84cb563386a179ea.
- Backpressure:
  - Stimulus: hold m_ready low 10 cycles in OUT.
  - Required: m_data and m_valid stable, s_ready 0, no second core_start; release produces exactly one handshake.
- Timeout:
  - Stimulus: core model never asserts core_valid, TIMEOUT_CYCLES = 8.
  - Required: err_timeout pulses once, 8 cycles after core_start; no m_valid; next block reloads cfg_iv.
- Reset mid-WAIT:
  - Stimulus: rst_n low for one edge during WAIT, then core_valid arrives.
  - Required: all outputs at reset values; m_valid stays 0; s_ready 1 the cycle after rst_n returns high.
